// File: rtl/bg_model_reader.sv
// bg_model_reader: joins background-model records with camera pixels and emits a K*sigma foreground mask stream.
module bg_model_reader #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 180,
  parameter int DATA_WIDTH = 336,
  parameter int K          = 3,
  parameter int MIN_SIGMA  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  model_tvalid,
  output logic                  model_tready,
  input  logic [DATA_WIDTH-1:0] model_tdata,
  input  logic                  model_tlast,
  input  logic                  pixel_tvalid,
  output logic                  pixel_tready,
  input  logic [23:0]           pixel_tdata,
  input  logic                  pixel_tlast,
  output logic                  mask_tvalid,
  input  logic                  mask_tready,
  output logic                  mask_tdata,
  output logic [2:0]            mask_tuser,
  output logic                  mask_tlast,
  output logic                  frame_done,
  output logic                  sync_err
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic m_flag_q, m_flag_d, p_flag_q, p_flag_d, sync_err_q, sync_err_d;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [2:0][35:0] thr_q, thr_d, thr_n;
  logic [2:0][32:0] diff_q, diff_d, diff_n;
  logic mask_tvalid_q, mask_tvalid_d, mask_tdata_q, mask_tdata_d, mask_tlast_q, mask_tlast_d;
  logic [2:0] mask_tuser_q, mask_tuser_d, flag;
  logic frame_done_q, frame_done_d;
  logic en, join_fire, at_end, err, mf, pf;
  logic unused_hi;
  assign unused_hi = ^model_tdata[DATA_WIDTH-1:192];
  // channel c: 0=B, 1=G, 2=R; sigma floor folds the negative case into the MIN_SIGMA compare
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [31:0] sd;
    logic [31:0] sig;
    logic [32:0] d;
    assign sd = model_tdata[96+32*c +: 32];
    assign sig = (sd < MIN_SIGMA) ? 32'(MIN_SIGMA) : sd;
    assign d = {25'b0, pixel_tdata[8*c +: 8]} - {model_tdata[32*c+31], model_tdata[32*c +: 32]};
    assign thr_n[c] = 36'(K) * {4'b0, sig};
    assign diff_n[c] = d[32] ? -d : d;
    assign flag[c] = {3'b0, diff_q[c]} > thr_q[c];
  end
  always_comb begin
    en = !mask_tvalid_q | mask_tready;
    join_fire = (state_q == RUN) & model_tvalid & pixel_tvalid & en;
    at_end = pix_cnt_q == CW'(TOTAL - 1);
    err = join_fire & ((model_tlast != at_end) | (pixel_tlast != at_end));
    model_tready = (state_q == RUN) ? join_fire : !m_flag_q;
    pixel_tready = (state_q == RUN) ? join_fire : !p_flag_q;
    mf = m_flag_q | (model_tvalid & model_tready & model_tlast);
    pf = p_flag_q | (pixel_tvalid & pixel_tready & pixel_tlast);
    state_d = state_q;
    pix_cnt_d = pix_cnt_q;
    m_flag_d = m_flag_q;
    p_flag_d = p_flag_q;
    sync_err_d = sync_err_q | err;
    if (state_q == RUN) begin
      if (join_fire) pix_cnt_d = (at_end | err) ? '0 : pix_cnt_q + 1'b1;
      if (err) begin
        state_d = DRAIN;
        m_flag_d = model_tlast;
        p_flag_d = pixel_tlast;
      end
    end else if (mf & pf) begin
      state_d = RUN;
      pix_cnt_d = '0;
      m_flag_d = 1'b0;
      p_flag_d = 1'b0;
    end else begin
      m_flag_d = mf;
      p_flag_d = pf;
    end
    s1_valid_d = en ? join_fire : s1_valid_q;
    s1_last_d = en ? (at_end | err) : s1_last_q;
    thr_d = en ? thr_n : thr_q;
    diff_d = en ? diff_n : diff_q;
    mask_tvalid_d = en ? s1_valid_q : mask_tvalid_q;
    mask_tdata_d = en ? |flag : mask_tdata_q;
    mask_tuser_d = en ? flag : mask_tuser_q;
    mask_tlast_d = en ? s1_last_q : mask_tlast_q;
    frame_done_d = mask_tvalid_q & mask_tready & mask_tlast_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pix_cnt_q <= '0;
      m_flag_q <= 1'b0;
      p_flag_q <= 1'b0;
      sync_err_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      thr_q <= '0;
      diff_q <= '0;
      mask_tvalid_q <= 1'b0;
      mask_tdata_q <= 1'b0;
      mask_tuser_q <= '0;
      mask_tlast_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_cnt_q <= pix_cnt_d;
      m_flag_q <= m_flag_d;
      p_flag_q <= p_flag_d;
      sync_err_q <= sync_err_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      thr_q <= thr_d;
      diff_q <= diff_d;
      mask_tvalid_q <= mask_tvalid_d;
      mask_tdata_q <= mask_tdata_d;
      mask_tuser_q <= mask_tuser_d;
      mask_tlast_q <= mask_tlast_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign mask_tvalid = mask_tvalid_q;
  assign mask_tdata = mask_tdata_q;
  assign mask_tuser = mask_tuser_q;
  assign mask_tlast = mask_tlast_q;
  assign frame_done = frame_done_q;
  assign sync_err = sync_err_q;
endmodule

// File: tb/tb_bg_model_reader.sv
// tb_bg_model_reader: directed frames on a 4x2 image with a queue scoreboard checking every mask beat.
module tb_bg_model_reader;
  logic clk = 0, rst = 1;
  logic model_tvalid = 0, model_tlast = 0, pixel_tvalid = 0, pixel_tlast = 0, mask_tready = 1;
  logic [335:0] model_tdata = '0;
  logic [23:0] pixel_tdata = '0;
  logic model_tready, pixel_tready, mask_tvalid, mask_tdata, mask_tlast, frame_done, sync_err;
  logic [2:0] mask_tuser;
  int checks = 0, errors = 0, fd_cnt = 0;
  logic [4:0] q[$];
  bg_model_reader #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(336), .K(3), .MIN_SIGMA(2)) dut (
    .clk(clk), .rst(rst),
    .model_tvalid(model_tvalid), .model_tready(model_tready), .model_tdata(model_tdata), .model_tlast(model_tlast),
    .pixel_tvalid(pixel_tvalid), .pixel_tready(pixel_tready), .pixel_tdata(pixel_tdata), .pixel_tlast(pixel_tlast),
    .mask_tvalid(mask_tvalid), .mask_tready(mask_tready), .mask_tdata(mask_tdata), .mask_tuser(mask_tuser),
    .mask_tlast(mask_tlast), .frame_done(frame_done), .sync_err(sync_err));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (!rst && mask_tvalid && mask_tready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mask: got %0h with empty scoreboard", {mask_tdata, mask_tuser, mask_tlast});
      end else chk("mask_beat", 64'({mask_tdata, mask_tuser, mask_tlast}), 64'(q.pop_front()));
    end
  end
  function automatic logic [255:0] rec(input int mr, input int mg, input int mb, input int sd);
    return {32'hdeadbeef, 32'hcafef00d, sd, sd, sd, mr, mg, mb};
  endfunction
  function automatic logic [23:0] px(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction
  task automatic beat(input logic [255:0] r, input logic [23:0] p, input logic ml, input logic pl,
                      input logic push, input logic [4:0] e);
    int n = 0;
    model_tdata = {{80{1'b1}}, r};
    pixel_tdata = p;
    model_tlast = ml;
    pixel_tlast = pl;
    model_tvalid = 1;
    pixel_tvalid = 1;
    if (push) q.push_back(e);
    forever begin
      @(negedge clk);
      if (model_tready && pixel_tready) break;
      if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL join_timeout: readies %b%b required 11", model_tready, pixel_tready);
        break;
      end
    end
    @(posedge clk);
    #1 model_tvalid = 0;
    pixel_tvalid = 0;
  endtask
  task automatic model_only(input logic [255:0] r, input logic ml);
    int n = 0;
    model_tdata = {80'd0, r};
    model_tlast = ml;
    model_tvalid = 1;
    forever begin
      @(negedge clk);
      if (model_tready) break;
      if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: model_tready %b required 1", model_tready);
        break;
      end
    end
    @(posedge clk);
    #1 model_tvalid = 0;
  endtask
  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 || mask_tvalid) begin
      @(negedge clk);
      if (++n > 300) begin
        checks++;
        errors++;
        $display("FAIL drain_wait: %0d beats missing", q.size());
        q.delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [255:0] m100 = rec(100, 100, 100, 5);
    logic [2:0] b;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 64'({mask_tvalid, mask_tdata, mask_tuser, mask_tlast, frame_done, sync_err,
                                 model_tready, pixel_tready}), 0);
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(m100, px(110, 110, 110), i == 7, i == 7, 1, {4'b0, i == 7});
    wait_empty();
    chk("frame1_done_count", 64'(fd_cnt), 1);
    chk("frame1_sync_err", 64'(sync_err), 0);
    beat(m100, px(116, 100, 84), 0, 0, 1, 5'b1_101_0);
    beat(m100, px(115, 85, 100), 0, 0, 1, 5'b0_000_0);
    beat(rec(50, 50, 50, 0), px(57, 57, 57), 0, 0, 1, 5'b1_111_0);
    beat(rec(50, 50, 50, -4), px(56, 56, 56), 0, 0, 1, 5'b0_000_0);
    beat(rec(50, 50, 50, -4), px(57, 50, 44), 0, 0, 1, 5'b1_100_0);
    beat(rec(300, -10, 0, 1), px(255, 0, 3), 0, 0, 1, 5'b1_110_0);
    beat(rec(100, 100, 100, 100), px(0, 0, 0), 0, 0, 1, 5'b0_000_0);
    beat(m100, px(100, 100, 100), 1, 1, 1, 5'b0_000_1);
    wait_empty();
    chk("frame2_done_count", 64'(fd_cnt), 2);
    fork
      for (int i = 0; i < 8; i++) begin
        b = 3'(i);
        beat(m100, px(b[2] ? 120 : 100, b[1] ? 120 : 100, b[0] ? 120 : 100), i == 7, i == 7, 1,
             {|b, b, i == 7});
      end
      begin
        repeat (8) begin
          @(posedge clk);
          #1 mask_tready = ~mask_tready;
        end
        mask_tready = 0;
        repeat (20) begin
          @(negedge clk);
          if (mask_tvalid) chk("stall_readies", 64'({model_tready, pixel_tready}), 0);
        end
        @(posedge clk);
        #1 mask_tready = 1;
      end
    join
    wait_empty();
    chk("frame3_done_count", 64'(fd_cnt), 3);
    for (int i = 0; i < 4; i++) beat(m100, px(110, 130, 110), 0, 0, 1, 5'b1_010_0);
    beat(m100, px(110, 110, 110), 0, 1, 1, 5'b0_000_1);
    model_only(m100, 0);
    model_only(m100, 0);
    model_only(m100, 1);
    wait_empty();
    chk("misalign_sync_err", 64'(sync_err), 1);
    chk("misalign_done_count", 64'(fd_cnt), 4);
    for (int i = 0; i < 8; i++)
      beat(m100, i == 2 ? px(116, 116, 116) : px(110, 110, 110), i == 7, i == 7, 1,
           i == 2 ? 5'b1_111_0 : {4'b0, i == 7});
    wait_empty();
    chk("resync_sync_err_sticky", 64'(sync_err), 1);
    chk("resync_done_count", 64'(fd_cnt), 5);
    mask_tready = 0;
    beat(m100, px(200, 100, 100), 0, 0, 0, 5'b0);
    beat(m100, px(200, 100, 100), 0, 0, 0, 5'b0);
    #2 rst = 1;
    #1 chk("midframe_reset_outputs", 64'({mask_tvalid, mask_tdata, mask_tuser, mask_tlast, frame_done, sync_err}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mask_tready = 1;
    for (int i = 0; i < 8; i++)
      beat(m100, i == 0 ? px(200, 100, 100) : px(110, 110, 110), i == 7, i == 7, 1,
           i == 0 ? 5'b1_100_0 : {4'b0, i == 7});
    wait_empty();
    chk("after_reset_sync_err", 64'(sync_err), 0);
    chk("after_reset_done_count", 64'(fd_cnt), 6);
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
